// File: rtl/fir_axi_pkg.sv
// Shared definitions for the FIR-side AXI responder.
// Contents:
//   - Register offsets within the 8-bit decode window.
//   - ap_ctrl bit positions.
//   - Run-control state enum.
//   - Stream beat payload.
//   - Byte-strobe merge helper.
package fir_axi_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [7:0] OFS_AP_CTRL  = 8'h00;
    localparam logic [7:0] OFS_DATA_LEN = 8'h10;
    localparam logic [7:0] OFS_NUM_TAPS = 8'h14;
    localparam logic [7:0] OFS_TAP_BASE = 8'h80;

    localparam int unsigned AP_START_BIT   = 0;
    localparam int unsigned AP_DONE_BIT    = 1;
    localparam int unsigned AP_IDLE_BIT    = 2;
    localparam int unsigned AP_X_READY_BIT = 4;
    localparam int unsigned AP_Y_READY_BIT = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ap_state_e;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } axis_beat_t;

    // Merge wdata into an existing register value byte by byte.
    function automatic logic [DATA_W-1:0] apply_wstrb(input logic [DATA_W-1:0] old_val,
                                                      input logic [DATA_W-1:0] new_val,
                                                      input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int i = 0; i < int'(STRB_W); i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axis_skid1.sv
// One-entry valid/ready buffer for a 32-bit data + last beat.
// Adds one cycle of latency and sustains a beat per cycle: a new beat is
// taken whenever the slot is empty or is being drained in the same cycle.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   flush                synchronous empty of the slot
//   s_valid/s_beat       upstream beat (caller gates s_valid with its own
//                        readiness conditions)
//   s_ready_c            slot can take a beat this cycle
//   m_valid/m_beat       buffered beat
//   m_ready              downstream accepts the buffered beat
module axis_skid1
    import fir_axi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       s_valid,
    input  axis_beat_t s_beat,
    output logic       s_ready_c,
    output logic       m_valid,
    output axis_beat_t m_beat,
    input  logic       m_ready
);

    assign s_ready_c = !m_valid || m_ready;

    // Slot occupancy and payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_beat  <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (s_valid && s_ready_c) begin
            m_valid <= 1'b1;
            m_beat  <= s_beat;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fir_axi_responder.sv
// FIR-side endpoint of the Wishbone-to-AXI bridge: AXI-Lite register and tap
// space, X/Y stream buffering between bridge and FIR core, and the
// ap_start/ap_done/ap_idle run control with per-run sample counters.
// Ports:
//   axis_clk, axis_rst_n        clock, async active-low reset
//   aw*/w*/b*                   AXI-Lite write (no bresp)
//   ar*/r*                      AXI-Lite read (no rresp)
//   ss_*                        X stream from bridge (tlast ignored)
//   sm_*                        Y stream to bridge
//   core_x_*, core_y_*          X to / Y from the FIR core
//   core_start                  one-cycle pulse when a run starts
//   data_length, num_taps       register values
//   tap_raddr/tap_rdata         combinational core read port into taps
module fir_axi_responder
    import fir_axi_pkg::*;
#(
    parameter int unsigned NUM_TAPS_MAX = 32
) (
    input  logic        axis_clk,
    input  logic        axis_rst_n,

    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,

    input  logic        ss_tvalid,
    output logic        ss_tready,
    input  logic [31:0] ss_tdata,
    input  logic        ss_tlast,
    output logic        sm_tvalid,
    input  logic        sm_tready,
    output logic [31:0] sm_tdata,
    output logic        sm_tlast,

    output logic        core_x_valid,
    input  logic        core_x_ready,
    output logic [31:0] core_x_data,
    input  logic        core_y_valid,
    output logic        core_y_ready,
    input  logic [31:0] core_y_data,
    output logic        core_start,

    output logic [31:0] data_length,
    output logic [31:0] num_taps,
    input  logic [4:0]  tap_raddr,
    output logic [31:0] tap_rdata
);

    localparam int unsigned TAP_IDX_W = $clog2(NUM_TAPS_MAX);

    // Tap index falls inside the implemented tap file (depth is a power of two).
    function automatic logic tap_hit(input logic [4:0] idx);
        return (idx & ~5'(NUM_TAPS_MAX - 1)) == 5'd0;
    endfunction

    ap_state_e         state_q, state_d;
    logic              start_c;
    logic              run_c;

    logic [7:0]        aw_addr_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;
    logic              commit_c;
    logic              wr_ok_c;
    logic              ap_wr_c;

    logic [31:0]       taps [NUM_TAPS_MAX];
    logic [31:0]       ap_ctrl_c;
    logic [31:0]       rd_data_c;

    logic [31:0]       x_cnt_q, y_cnt_q;
    logic              x_s_ready_c, y_s_ready_c;
    axis_beat_t        x_in_beat, x_out_beat;
    axis_beat_t        y_in_beat, y_out_beat;
    logic              sm_last_hs_c;

    logic              unused_c;
    assign unused_c = ^{ss_tlast, awaddr[31:8], araddr[31:8], x_out_beat.last};

    assign run_c = (state_q == RUN);

    // ---------------- AXI-Lite write channel ----------------
    // A write commits once both AW and W are held and no response is pending.
    assign commit_c = !awready && !wready && !bvalid;
    // Everything except the run-control FSM ignores writes during a run.
    assign wr_ok_c  = commit_c && !run_c;
    assign ap_wr_c  = commit_c && (aw_addr_q == OFS_AP_CTRL);

    // Independent AW/W capture; readiness returns after the B handshake.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            awready   <= 1'b1;
            wready    <= 1'b1;
            bvalid    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (awvalid && awready) begin
                awready   <= 1'b0;
                aw_addr_q <= awaddr[7:0];
            end
            if (wvalid && wready) begin
                wready   <= 1'b0;
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            if (commit_c) begin
                bvalid <= 1'b1;
            end
            if (bvalid && bready) begin
                bvalid  <= 1'b0;
                awready <= 1'b1;
                wready  <= 1'b1;
            end
        end
    end

    // Configuration registers and tap file.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            data_length <= '0;
            num_taps    <= '0;
            for (int i = 0; i < int'(NUM_TAPS_MAX); i++) begin
                taps[i] <= '0;
            end
        end else if (wr_ok_c) begin
            if (aw_addr_q[7]) begin
                if (tap_hit(aw_addr_q[6:2])) begin
                    taps[aw_addr_q[2 +: TAP_IDX_W]] <=
                        apply_wstrb(taps[aw_addr_q[2 +: TAP_IDX_W]], w_data_q, w_strb_q);
                end
            end else if (aw_addr_q == OFS_DATA_LEN) begin
                data_length <= apply_wstrb(data_length, w_data_q, w_strb_q);
            end else if (aw_addr_q == OFS_NUM_TAPS) begin
                num_taps <= apply_wstrb(num_taps, w_data_q, w_strb_q);
            end
        end
    end

    // ---------------- AXI-Lite read channel ----------------
    assign arready = !rvalid;

    // Status word assembled from live state.
    always_comb begin
        ap_ctrl_c                 = '0;
        ap_ctrl_c[AP_START_BIT]   = run_c;
        ap_ctrl_c[AP_DONE_BIT]    = (state_q == DONE);
        ap_ctrl_c[AP_IDLE_BIT]    = !run_c;
        ap_ctrl_c[AP_X_READY_BIT] = ss_tready;
        ap_ctrl_c[AP_Y_READY_BIT] = sm_tvalid;
    end

    // Read decode; taps are masked as all-ones while the core owns them.
    always_comb begin
        rd_data_c = '0;
        if (araddr[7]) begin
            if (run_c) begin
                rd_data_c = '1;
            end else if (tap_hit(araddr[6:2])) begin
                rd_data_c = taps[araddr[2 +: TAP_IDX_W]];
            end
        end else begin
            case (araddr[7:0])
                OFS_AP_CTRL:  rd_data_c = ap_ctrl_c;
                OFS_DATA_LEN: rd_data_c = data_length;
                OFS_NUM_TAPS: rd_data_c = num_taps;
                default:      rd_data_c = '0;
            endcase
        end
    end

    // Registered read response.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else if (arvalid && arready) begin
            rvalid <= 1'b1;
            rdata  <= rd_data_c;
        end else if (rready) begin
            rvalid <= 1'b0;
        end
    end

    // Core-side combinational tap read.
    assign tap_rdata = tap_hit(tap_raddr) ? taps[tap_raddr[TAP_IDX_W-1:0]] : '0;

    // ---------------- Run-control FSM ----------------
    assign sm_last_hs_c = sm_tvalid && sm_tready && sm_tlast;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Start takes priority over the done-clear bit.
    always_comb begin
        state_d = state_q;
        start_c = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (ap_wr_c && w_data_q[AP_START_BIT]) begin
                    state_d = RUN;
                    start_c = 1'b1;
                end else if ((state_q == DONE) && ap_wr_c && w_data_q[AP_DONE_BIT]) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if ((data_length == 32'd0) || sm_last_hs_c) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            core_start <= 1'b0;
        end else begin
            core_start <= start_c;
        end
    end

    // ---------------- Stream paths ----------------
    assign ss_tready    = run_c && (x_cnt_q < data_length) && x_s_ready_c;
    assign core_y_ready = run_c && y_s_ready_c;

    assign x_in_beat.data = ss_tdata;
    assign x_in_beat.last = 1'b0;
    // Tag the beat that completes the run so the bridge sees tlast.
    assign y_in_beat.data = core_y_data;
    assign y_in_beat.last = ((y_cnt_q + 32'd1) == data_length);

    // Sample counters, cleared at each start.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            x_cnt_q <= '0;
            y_cnt_q <= '0;
        end else if (start_c) begin
            x_cnt_q <= '0;
            y_cnt_q <= '0;
        end else begin
            if (ss_tvalid && ss_tready) begin
                x_cnt_q <= x_cnt_q + 32'd1;
            end
            if (core_y_valid && core_y_ready) begin
                y_cnt_q <= y_cnt_q + 32'd1;
            end
        end
    end

    axis_skid1 u_x_buf (
        .clk       (axis_clk),
        .rst_n     (axis_rst_n),
        .flush     (start_c),
        .s_valid   (ss_tvalid && ss_tready),
        .s_beat    (x_in_beat),
        .s_ready_c (x_s_ready_c),
        .m_valid   (core_x_valid),
        .m_beat    (x_out_beat),
        .m_ready   (core_x_ready)
    );

    axis_skid1 u_y_buf (
        .clk       (axis_clk),
        .rst_n     (axis_rst_n),
        .flush     (start_c),
        .s_valid   (core_y_valid && core_y_ready),
        .s_beat    (y_in_beat),
        .s_ready_c (y_s_ready_c),
        .m_valid   (sm_tvalid),
        .m_beat    (y_out_beat),
        .m_ready   (sm_tready)
    );

    assign core_x_data = x_out_beat.data;
    assign sm_tdata    = y_out_beat.data;
    assign sm_tlast    = y_out_beat.last;

endmodule

// File: tb/tb_fir_axi_responder.sv
// Self-checking bench for fir_axi_responder: AXI-Lite register traffic,
// run control, and X/Y stream scoreboards with latency checks.
module tb_fir_axi_responder;
    import fir_axi_pkg::*;

    logic        axis_clk = 1'b0;
    logic        axis_rst_n;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] awaddr, wdata;
    logic [3:0]  wstrb;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] araddr, rdata;
    logic        ss_tvalid, ss_tready, ss_tlast;
    logic [31:0] ss_tdata;
    logic        sm_tvalid, sm_tready, sm_tlast;
    logic [31:0] sm_tdata;
    logic        core_x_valid, core_x_ready, core_y_valid, core_y_ready, core_start;
    logic [31:0] core_x_data, core_y_data, data_length, num_taps, tap_rdata;
    logic [4:0]  tap_raddr;

    fir_axi_responder #(.NUM_TAPS_MAX(32)) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
        .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast),
        .core_x_valid(core_x_valid), .core_x_ready(core_x_ready), .core_x_data(core_x_data),
        .core_y_valid(core_y_valid), .core_y_ready(core_y_ready), .core_y_data(core_y_data),
        .core_start(core_start), .data_length(data_length), .num_taps(num_taps),
        .tap_raddr(tap_raddr), .tap_rdata(tap_rdata)
    );

    always #5 axis_clk = ~axis_clk;

    int cyc = 0;
    always @(posedge axis_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboards ----------------
    typedef struct {
        logic [31:0] data;
        logic        last;
        int          cyc;
    } sb_item_t;

    sb_item_t xq[$];
    sb_item_t yq[$];
    int  y_num = 0;
    int  dl_model = 0;
    bit  y_lat_chk = 1'b0;
    int  start_pulses = 0;

    // X into the responder.
    always @(negedge axis_clk) begin
        if (axis_rst_n && ss_tvalid && ss_tready)
            xq.push_back('{data: ss_tdata, last: 1'b0, cyc: cyc + 1});
    end

    // X out to the core: data in order, one cycle after acceptance.
    always @(negedge axis_clk) begin
        sb_item_t e;
        if (axis_rst_n && core_x_valid && core_x_ready) begin
            check_eq("x_sb_nonempty", 32'(xq.size() != 0), 32'd1);
            if (xq.size() != 0) begin
                e = xq.pop_front();
                check_eq("x_data", core_x_data, e.data);
                check_eq("x_latency", 32'(cyc + 1 - e.cyc), 32'd1);
            end
        end
    end

    // Y from the core; the bench numbers beats to know which one is last.
    always @(negedge axis_clk) begin
        if (axis_rst_n && core_y_valid && core_y_ready) begin
            y_num = y_num + 1;
            yq.push_back('{data: core_y_data, last: (y_num == dl_model), cyc: cyc + 1});
        end
    end

    always @(negedge axis_clk) begin
        sb_item_t e;
        if (axis_rst_n && sm_tvalid && sm_tready) begin
            check_eq("y_sb_nonempty", 32'(yq.size() != 0), 32'd1);
            if (yq.size() != 0) begin
                e = yq.pop_front();
                check_eq("y_data", sm_tdata, e.data);
                check_eq("y_last", 32'(sm_tlast), 32'(e.last));
                if (y_lat_chk)
                    check_eq("y_latency", 32'(cyc + 1 - e.cyc), 32'd1);
            end
        end
    end

    always @(negedge axis_clk) begin
        if (axis_rst_n && core_start) start_pulses = start_pulses + 1;
    end

    // ---------------- bus tasks ----------------
    task automatic axil_write(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input int lead, output int b_lat);
        int t;
        awvalid = 1'b1;
        awaddr  = a;
        if (lead == 0) begin
            wvalid = 1'b1; wdata = d; wstrb = s;
        end
        t = 0;
        @(negedge axis_clk);
        while (!(awready && (lead != 0 || wready)) && t < 20) begin
            @(negedge axis_clk); t++;
        end
        if (!awready) check_eq("aw_timeout", 32'(awready), 32'd1);
        @(posedge axis_clk); #1;
        awvalid = 1'b0;
        if (lead == 0) begin
            wvalid = 1'b0;
        end else begin
            repeat (lead - 1) begin @(posedge axis_clk); #1; end
            wvalid = 1'b1; wdata = d; wstrb = s;
            t = 0;
            @(negedge axis_clk);
            while (!wready && t < 20) begin @(negedge axis_clk); t++; end
            if (!wready) check_eq("w_timeout", 32'(wready), 32'd1);
            @(posedge axis_clk); #1;
            wvalid = 1'b0;
        end
        b_lat = 0;
        @(negedge axis_clk);
        while (!bvalid && b_lat < 20) begin b_lat++; @(negedge axis_clk); end
        if (!bvalid) check_eq("b_timeout", 32'(bvalid), 32'd1);
        @(posedge axis_clk); #1;
    endtask

    task automatic axil_read(input logic [31:0] a, output logic [31:0] d);
        int t;
        arvalid = 1'b1;
        araddr  = a;
        t = 0;
        @(negedge axis_clk);
        while (!arready && t < 20) begin @(negedge axis_clk); t++; end
        if (!arready) check_eq("ar_timeout", 32'(arready), 32'd1);
        @(posedge axis_clk); #1;
        arvalid = 1'b0;
        t = 0;
        @(negedge axis_clk);
        while (!rvalid && t < 20) begin @(negedge axis_clk); t++; end
        if (!rvalid) check_eq("r_timeout", 32'(rvalid), 32'd1);
        d = rdata;
        @(posedge axis_clk); #1;
    endtask

    task automatic send_x(input logic [31:0] v);
        int t;
        ss_tvalid = 1'b1; ss_tdata = v; t = 0;
        @(negedge axis_clk);
        while (!ss_tready && t < 30) begin @(negedge axis_clk); t++; end
        if (!ss_tready) check_eq("ss_timeout", 32'(ss_tready), 32'd1);
        @(posedge axis_clk); #1;
        ss_tvalid = 1'b0;
    endtask

    task automatic send_y(input logic [31:0] v);
        int t;
        core_y_valid = 1'b1; core_y_data = v; t = 0;
        @(negedge axis_clk);
        while (!core_y_ready && t < 30) begin @(negedge axis_clk); t++; end
        if (!core_y_ready) check_eq("cy_timeout", 32'(core_y_ready), 32'd1);
        @(posedge axis_clk); #1;
        core_y_valid = 1'b0;
    endtask

    task automatic check_reset(input string p);
        check_eq({p, "_awready"},  32'(awready), 32'd1);
        check_eq({p, "_wready"},   32'(wready), 32'd1);
        check_eq({p, "_arready"},  32'(arready), 32'd1);
        check_eq({p, "_bvalid"},   32'(bvalid), 32'd0);
        check_eq({p, "_rvalid"},   32'(rvalid), 32'd0);
        check_eq({p, "_rdata"},    rdata, 32'd0);
        check_eq({p, "_ss_tready"}, 32'(ss_tready), 32'd0);
        check_eq({p, "_sm_tvalid"}, 32'(sm_tvalid), 32'd0);
        check_eq({p, "_sm_tdata"}, sm_tdata, 32'd0);
        check_eq({p, "_sm_tlast"}, 32'(sm_tlast), 32'd0);
        check_eq({p, "_cx_valid"}, 32'(core_x_valid), 32'd0);
        check_eq({p, "_cx_data"},  core_x_data, 32'd0);
        check_eq({p, "_cy_ready"}, 32'(core_y_ready), 32'd0);
        check_eq({p, "_start"},    32'(core_start), 32'd0);
        check_eq({p, "_dlen"},     data_length, 32'd0);
        check_eq({p, "_ntaps"},    num_taps, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d limit reached", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] rd;
        int bl;
        int w_edge;
        int t;
        axis_rst_n = 1'b0;
        awvalid = 0; awaddr = 0; wvalid = 0; wdata = 0; wstrb = 0; bready = 1;
        arvalid = 0; araddr = 0; rready = 1;
        ss_tvalid = 0; ss_tdata = 0; ss_tlast = 0; sm_tready = 0;
        core_x_ready = 0; core_y_valid = 0; core_y_data = 0; tap_raddr = 0;

        repeat (3) @(negedge axis_clk);
        check_reset("rst");
        @(posedge axis_clk); #1;
        axis_rst_n = 1'b1;
        @(posedge axis_clk); #1;

        axil_read(32'h00, rd); check_eq("ap_ctrl_reset", rd, 32'h04);
        axil_read(32'h84, rd); check_eq("tap1_reset", rd, 32'h0);

        // Configuration with AW leading W by one cycle.
        axil_write(32'h10, 32'd4, 4'hF, 1, bl);       check_eq("b_lat_dlen", 32'(bl), 32'd1);
        axil_write(32'h14, 32'd11, 4'hF, 1, bl);      check_eq("b_lat_ntaps", 32'(bl), 32'd1);
        axil_write(32'h8C, 32'h1234, 4'hF, 1, bl);    check_eq("b_lat_tap3", 32'(bl), 32'd1);
        axil_read(32'h10, rd); check_eq("rd_dlen", rd, 32'd4);
        axil_read(32'h14, rd); check_eq("rd_ntaps", rd, 32'd11);
        axil_read(32'h8C, rd); check_eq("rd_tap3", rd, 32'h1234);
        tap_raddr = 5'd3; #1;
        check_eq("core_tap3", tap_rdata, 32'h1234);
        check_eq("port_dlen", data_length, 32'd4);
        check_eq("port_ntaps", num_taps, 32'd11);

        // Byte strobes and an unmapped write.
        axil_write(32'h14, 32'hAABBCCDD, 4'b0010, 0, bl);
        axil_read(32'h14, rd); check_eq("rd_ntaps_strb", rd, 32'h0000CC0B);
        axil_write(32'h20, 32'h55, 4'hF, 0, bl);      check_eq("b_lat_unmapped", 32'(bl), 32'd1);
        axil_read(32'h20, rd); check_eq("rd_unmapped", rd, 32'h0);

        // Start a 4-sample run.
        dl_model = 4; y_num = 0; core_x_ready = 1'b1;
        axil_write(32'h00, 32'h1, 4'hF, 0, bl);
        axil_read(32'h00, rd); check_eq("ap_ctrl_run", rd, 32'h11);
        for (int i = 1; i <= 4; i++) send_x(32'(i));
        ss_tvalid = 1'b1; ss_tdata = 32'd5;
        @(negedge axis_clk); check_eq("ss_tready_after4", 32'(ss_tready), 32'd0);
        @(negedge axis_clk); check_eq("ss_tready_after4b", 32'(ss_tready), 32'd0);
        @(posedge axis_clk); #1; ss_tvalid = 1'b0;

        // Writes during a run are dropped; tap reads are masked.
        axil_write(32'h80, 32'd5, 4'hF, 0, bl);
        tap_raddr = 5'd0; #1;
        check_eq("tap0_run_write", tap_rdata, 32'h0);
        axil_read(32'h80, rd); check_eq("rd_tap_run", rd, 32'hFFFF_FFFF);
        axil_write(32'h10, 32'd7, 4'hF, 0, bl);
        axil_read(32'h10, rd); check_eq("rd_dlen_run", rd, 32'd4);
        axil_write(32'h00, 32'h1, 4'hF, 0, bl);

        // Y results: two streamed, then back-pressure on the third.
        sm_tready = 1'b1; y_lat_chk = 1'b1;
        send_y(32'd10);
        send_y(32'd20);
        repeat (2) begin @(posedge axis_clk); #1; end
        y_lat_chk = 1'b0; sm_tready = 1'b0;
        send_y(32'd30);
        core_y_valid = 1'b1; core_y_data = 32'd40;
        for (int i = 0; i < 3; i++) begin
            @(negedge axis_clk);
            check_eq("y_hold_cy_ready", 32'(core_y_ready), 32'd0);
            check_eq("y_hold_valid", 32'(sm_tvalid), 32'd1);
            check_eq("y_hold_data", sm_tdata, 32'd30);
        end
        @(posedge axis_clk); #1;
        sm_tready = 1'b1;
        t = 0;
        @(negedge axis_clk);
        while (!core_y_ready && t < 20) begin @(negedge axis_clk); t++; end
        if (!core_y_ready) check_eq("cy_resume_timeout", 32'(core_y_ready), 32'd1);
        @(posedge axis_clk); #1;
        core_y_valid = 1'b0;
        repeat (3) begin @(posedge axis_clk); #1; end
        check_eq("x_sb_drained", 32'(xq.size()), 32'd0);
        check_eq("y_sb_drained", 32'(yq.size()), 32'd0);
        check_eq("y_beats_seen", 32'(y_num), 32'd4);
        axil_read(32'h00, rd); check_eq("ap_ctrl_done", rd, 32'h06);
        check_eq("start_pulses", 32'(start_pulses), 32'd1);
        axil_write(32'h00, 32'h2, 4'hF, 0, bl);
        axil_read(32'h00, rd); check_eq("ap_ctrl_idle", rd, 32'h04);

        // Zero-length run completes two cycles after the start write's W handshake.
        axil_write(32'h10, 32'd0, 4'hF, 0, bl);
        dl_model = 0; y_num = 0;
        fork
            axil_write(32'h00, 32'h1, 4'hF, 0, bl);
            begin
                t = 0;
                @(negedge axis_clk);
                while (!(wvalid && wready) && t < 20) begin @(negedge axis_clk); t++; end
                w_edge = cyc + 1;
                t = 0;
                while (dut.state_q != DONE && t < 20) begin @(negedge axis_clk); t++; end
                check_eq("dl0_done_delay", 32'(cyc - w_edge), 32'd2);
            end
        join
        check_eq("dl0_no_x", 32'(core_x_valid), 32'd0);
        check_eq("dl0_no_y", 32'(sm_tvalid), 32'd0);
        axil_read(32'h00, rd); check_eq("ap_ctrl_dl0", rd, 32'h06);

        // Reset in the middle of a run with full buffers and pending bus traffic.
        axil_write(32'h10, 32'd4, 4'hF, 0, bl);
        dl_model = 4; y_num = 0;
        core_x_ready = 1'b0; sm_tready = 1'b0;
        axil_write(32'h00, 32'h1, 4'hF, 0, bl);
        send_x(32'd77);
        send_y(32'd88);
        check_eq("pre_rst_cx_valid", 32'(core_x_valid), 32'd1);
        check_eq("pre_rst_sm_tvalid", 32'(sm_tvalid), 32'd1);
        rready = 1'b0;
        arvalid = 1'b1; araddr = 32'h10;
        awvalid = 1'b1; awaddr = 32'h14;
        @(posedge axis_clk); #1;
        arvalid = 1'b0; awvalid = 1'b0;
        @(negedge axis_clk);
        check_eq("pre_rst_rvalid", 32'(rvalid), 32'd1);
        check_eq("pre_rst_awready", 32'(awready), 32'd0);
        @(posedge axis_clk); #1;
        axis_rst_n = 1'b0;
        #1;
        check_reset("midrst");
        xq.delete(); yq.delete();
        repeat (2) begin @(posedge axis_clk); #1; end
        axis_rst_n = 1'b1;
        rready = 1'b1; core_x_ready = 1'b1; sm_tready = 1'b1;
        @(posedge axis_clk); #1;
        axil_read(32'h00, rd); check_eq("ap_ctrl_post_rst", rd, 32'h04);
        axil_read(32'h10, rd); check_eq("dlen_post_rst", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
